// File: rtl/multiplier_seq_8b.sv
// Sequential 8x8 unsigned shift-and-add multiplier with a val/rdy handshake on each side.
// One shared 8-bit ripple-carry adder is stepped through eight iterations by a three-state FSM.

module rca_8b #(
    parameter int W = 8
) (
    input  logic [W-1:0] in0_i,
    input  logic [W-1:0] in1_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);
    logic [W:0] c;
    assign c[0] = cin_i;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum_o[i] = in0_i[i] ^ in1_i[i] ^ c[i];
        assign c[i+1]   = (in0_i[i] & in1_i[i]) | (c[i] & (in0_i[i] ^ in1_i[i]));
    end

    assign cout_o = c[W];
endmodule

module multiplier_seq_8b #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [15:0] out_prod,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e     state_q, state_d;
    logic [7:0] hi_q, hi_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] a_q, a_d;
    logic [2:0] cnt_q, cnt_d;

    logic [7:0] addend, sum;
    logic       cout;

    assign addend = lo_q[0] ? a_q : 8'd0;

    rca_8b #(.W(8)) u_add (
        .in0_i  (hi_q),
        .in1_i  (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= 8'd0;
            lo_q    <= 8'd0;
            a_q     <= 8'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_val) begin
                    a_d     = in_a;
                    hi_d    = 8'd0;
                    lo_d    = in_b;
                    cnt_d   = 3'd0;
                    state_d = CALC;
                    if (SKIP_ZERO && (in_a == 8'd0 || in_b == 8'd0)) begin
                        lo_d    = 8'd0;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                // Carry-out shifts into hi[7], so the running product never loses a bit.
                hi_d  = {cout, sum[7:1]};
                lo_d  = {sum[0], lo_q[7:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = DONE;
            end
            DONE: begin
                if (out_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_rdy   = (state_q == IDLE);
    assign out_val  = (state_q == DONE);
    assign busy     = (state_q == CALC) || (state_q == DONE);
    assign out_prod = (state_q == DONE) ? {hi_q, lo_q} : 16'd0;
endmodule
